quad_decoder_4bit: RTL and testbench

QUAD_DECODER_4BIT -- requirements
Module: quad_decoder_4bit

---
 rtl/quad_decoder_4bit.sv | 155 +++++++++++++++
 tb/tb_quad_decoder_4bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder_4bit.sv
// rtl/quad_decoder_4bit.sv - synchronized 4-bit quadrature decoder with wrap and error flags
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   enable      1 = decoded steps update count, 0 = count frozen
//   clear       synchronous clear of count and err_sticky
//   quad_a/b    asynchronous quadrature phases, state code {quad_a, quad_b}
//   count       accumulated position (mod 16)
//   step        one-cycle pulse per accepted transition
//   up_down     direction of the most recent step (1 = up)
//   carry_out   one-cycle pulse on 15->0 (up) or 0->15 (down)
//   err_pulse   one-cycle pulse on a two-bit (illegal) transition
//   err_sticky  latched err_pulse, cleared by clear or reset
//   ready       1 once the synchronizer has been primed after reset
`timescale 1ns/1ps
module quad_decoder_4bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       quad_a,
  input  logic       quad_b,
  output logic [3:0] count,
  output logic       step,
  output logic       up_down,
  output logic       carry_out,
  output logic       err_pulse,
  output logic       err_sticky,
  output logic       ready
);

  localparam logic [2:0] WARM_LAST = 3'(SYNC_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
  logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
  logic [1:0]             prev_q, prev_d;
  logic [2:0]             warm_q, warm_d;
  logic                   ready_q, ready_d;
  logic [3:0]             count_q, count_d;
  logic                   step_q, step_d;
  logic                   up_down_q, up_down_d;
  logic                   carry_q, carry_d;
  logic                   err_pulse_q, err_pulse_d;
  logic                   err_sticky_q, err_sticky_d;

  logic [1:0] s_cur, s_next, pos_cur, pos_prev, delta;
  logic       is_up, is_down, is_err;

  // Gray state code mapped to a 2-bit position (00=0, 01=1, 11=2, 10=3) so the
  // modular difference directly gives +1 (up), -1 (down) or 2 (illegal jump).
  always_comb begin
    s_cur    = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    s_next   = {sync_a_q[SYNC_STAGES-2], sync_b_q[SYNC_STAGES-2]};
    pos_cur  = {s_cur[1], s_cur[1] ^ s_cur[0]};
    pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    delta    = pos_cur - pos_prev;
    is_up    = ready_q && (delta == 2'd1);
    is_down  = ready_q && (delta == 2'd3);
    is_err   = ready_q && (delta == 2'd2);
  end

  always_comb begin
    sync_a_d     = {sync_a_q[SYNC_STAGES-2:0], quad_a};
    sync_b_d     = {sync_b_q[SYNC_STAGES-2:0], quad_b};
    prev_d       = prev_q;
    warm_d       = warm_q;
    ready_d      = ready_q;
    count_d      = count_q;
    step_d       = 1'b0;
    up_down_d    = up_down_q;
    carry_d      = 1'b0;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;

    if (!ready_q) begin
      // During warm-up prev follows the value the last stage is about to load,
      // so prev already equals S when ready rises and no false event appears.
      prev_d = s_next;
      if (warm_q == WARM_LAST) begin
        ready_d = 1'b1;
      end else begin
        warm_d = warm_q + 3'd1;
      end
    end else begin
      prev_d = s_cur;
    end

    if (enable) begin
      if (is_up) begin
        count_d   = count_q + 4'd1;
        step_d    = 1'b1;
        up_down_d = 1'b1;
        carry_d   = (count_q == 4'hf);
      end else if (is_down) begin
        count_d   = count_q - 4'd1;
        step_d    = 1'b1;
        up_down_d = 1'b0;
        carry_d   = (count_q == 4'h0);
      end else if (is_err) begin
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
      end
    end

    // clear swallows any coincident step or error entirely; direction is kept.
    if (clear) begin
      count_d      = 4'd0;
      err_sticky_d = 1'b0;
      step_d       = 1'b0;
      carry_d      = 1'b0;
      err_pulse_d  = 1'b0;
      up_down_d    = up_down_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q     <= '0;
      sync_b_q     <= '0;
      prev_q       <= 2'b00;
      warm_q       <= 3'd0;
      ready_q      <= 1'b0;
      count_q      <= 4'd0;
      step_q       <= 1'b0;
      up_down_q    <= 1'b1;
      carry_q      <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      sync_a_q     <= sync_a_d;
      sync_b_q     <= sync_b_d;
      prev_q       <= prev_d;
      warm_q       <= warm_d;
      ready_q      <= ready_d;
      count_q      <= count_d;
      step_q       <= step_d;
      up_down_q    <= up_down_d;
      carry_q      <= carry_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign count      = count_q;
  assign step       = step_q;
  assign up_down    = up_down_q;
  assign carry_out  = carry_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_quad_decoder_4bit.sv
// tb/tb_quad_decoder_4bit.sv - directed self-checking bench for quad_decoder_4bit
`timescale 1ns/1ps
module tb_quad_decoder_4bit;

  logic       clk = 1'b0;
  logic       reset, enable, clear, quad_a, quad_b;
  logic [3:0] count;
  logic       step, up_down, carry_out, err_pulse, err_sticky, ready;

  int compared   = 0;
  int mismatched = 0;
  logic [1:0] pos = 2'd0;

  quad_decoder_4bit #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .quad_a     (quad_a),
    .quad_b     (quad_b),
    .count      (count),
    .step       (step),
    .up_down    (up_down),
    .carry_out  (carry_out),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pos(input logic [1:0] p);
    pos    = p;
    quad_a = p[1];
    quad_b = p[1] ^ p[0];
  endtask

  // One quadrature move held for 4 cycles; the result must appear exactly at
  // the second edge after the one that first samples the new level.
  task automatic move(input string tag, input bit up, input logic exp_step,
                      input logic [3:0] exp_count, input logic exp_ud, input logic exp_carry);
    drive_pos(up ? pos + 2'd1 : pos - 2'd1);
    tick();
    tick();
    chk({tag, "_early_step"}, {3'b0, step}, 4'd0);
    tick();
    chk({tag, "_step"}, {3'b0, step}, {3'b0, exp_step});
    chk({tag, "_count"}, count, exp_count);
    chk({tag, "_up_down"}, {3'b0, up_down}, {3'b0, exp_ud});
    chk({tag, "_carry"}, {3'b0, carry_out}, {3'b0, exp_carry});
    chk({tag, "_err"}, {3'b0, err_pulse}, 4'd0);
    tick();
    chk({tag, "_step_end"}, {3'b0, step}, 4'd0);
    chk({tag, "_carry_end"}, {3'b0, carry_out}, 4'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    drive_pos(2'd0);
    tick();
    tick();
    chk("rst_count", count, 4'd0);
    chk("rst_step", {3'b0, step}, 4'd0);
    chk("rst_up_down", {3'b0, up_down}, 4'd1);
    chk("rst_carry", {3'b0, carry_out}, 4'd0);
    chk("rst_err_pulse", {3'b0, err_pulse}, 4'd0);
    chk("rst_err_sticky", {3'b0, err_sticky}, 4'd0);
    chk("rst_ready", {3'b0, ready}, 4'd0);

    reset = 1'b0;
    tick();
    chk("warm1_ready", {3'b0, ready}, 4'd0);
    tick();
    chk("warm2_ready", {3'b0, ready}, 4'd1);

    // Up sequence 00,01,11,10,00
    enable = 1'b1;
    tick(); tick(); tick(); tick();
    chk("hold00_step", {3'b0, step}, 4'd0);
    move("up1", 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
    move("up2", 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
    move("up3", 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    move("up4", 1'b1, 1'b1, 4'd4, 1'b1, 1'b0);

    // Climb to 15, then wrap up and back down
    for (int i = 0; i < 11; i++) begin
      move("climb", 1'b1, 1'b1, 4'(5 + i), 1'b1, 1'b0);
    end
    move("wrap_up", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    move("wrap_dn", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    move("dn14", 1'b0, 1'b1, 4'd14, 1'b0, 1'b0);
    move("dn13", 1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
    move("dn12", 1'b0, 1'b1, 4'd12, 1'b0, 1'b0);

    // Illegal jump 00 -> 11
    drive_pos(2'd2);
    tick();
    tick();
    chk("err_early", {3'b0, err_pulse}, 4'd0);
    tick();
    chk("err_pulse", {3'b0, err_pulse}, 4'd1);
    chk("err_sticky", {3'b0, err_sticky}, 4'd1);
    chk("err_step", {3'b0, step}, 4'd0);
    chk("err_count", count, 4'd12);
    tick();
    chk("err_pulse_end", {3'b0, err_pulse}, 4'd0);
    chk("err_sticky_hold", {3'b0, err_sticky}, 4'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_count", count, 4'd0);
    chk("clr_sticky", {3'b0, err_sticky}, 4'd0);
    chk("clr_up_down", {3'b0, up_down}, 4'd0);

    // Disabled moves: count and direction frozen, prev still tracks
    enable = 1'b0;
    move("dis1", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    move("dis2", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    move("dis3", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    enable = 1'b1;
    tick(); tick(); tick();
    chk("reen_step", {3'b0, step}, 4'd0);
    chk("reen_count", count, 4'd0);
    chk("reen_err", {3'b0, err_pulse}, 4'd0);
    move("reen_up", 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);

    // clear coincident with a step
    drive_pos(pos + 2'd1);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrstep_count", count, 4'd0);
    chk("clrstep_step", {3'b0, step}, 4'd0);
    chk("clrstep_carry", {3'b0, carry_out}, 4'd0);
    tick();
    chk("clrstep_after", {3'b0, step}, 4'd0);
    chk("clrstep_cnt2", count, 4'd0);

    // Reset pulse with inputs at 10
    chk("pre_rst_inputs", {2'b0, quad_a, quad_b}, 4'b0010);
    move("pre_rst_dn", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
    drive_pos(2'd3);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_count", count, 4'd0);
    chk("rst2_up_down", {3'b0, up_down}, 4'd1);
    chk("rst2_ready", {3'b0, ready}, 4'd0);
    chk("rst2_step", {3'b0, step}, 4'd0);
    tick();
    chk("rst2_warm1_ready", {3'b0, ready}, 4'd0);
    chk("rst2_warm1_err", {3'b0, err_pulse}, 4'd0);
    tick();
    chk("rst2_warm2_ready", {3'b0, ready}, 4'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst2_quiet_err", {3'b0, err_pulse}, 4'd0);
      chk("rst2_quiet_step", {3'b0, step}, 4'd0);
      chk("rst2_quiet_count", count, 4'd0);
    end
    move("post_rst_up", 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
